// File: rtl/paillier_pkg.sv
// Shared definitions for the Paillier datapath blocks (mont_precompute, montexp).
package paillier_pkg;

    // Default operand width; R = 2^DEFAULT_WIDTH in the Montgomery domain.
    localparam int DEFAULT_WIDTH = 1024;

    // Sequencing states of the Montgomery constant precomputation.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } precomp_state_t;

endpackage

// File: rtl/mod_double.sv
// Combinational modular doubling: y = 2x mod n, valid whenever x < n.
module mod_double #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH-1:0] y_o
);

    logic [WIDTH:0]   dbl;
    logic [WIDTH-1:0] diff;

    // The doubled value keeps its carry bit so the compare against n sees
    // the true magnitude. When a subtraction is needed the result is below
    // n, so the low WIDTH bits of the wrapped difference are exact.
    always_comb begin
        dbl  = {x_i, 1'b0};
        diff = dbl[WIDTH-1:0] - n_i;
        y_o  = (dbl >= {1'b0, n_i}) ? diff : dbl[WIDTH-1:0];
    end

endmodule

// File: rtl/mont_precompute.sv
// Montgomery constant generator: r_mod = 2^WIDTH mod N and r2_mod = 2^(2*WIDTH) mod N,
// obtained by doubling 1 modulo N a total of 2*WIDTH times, UNROLL doublings per clock.
module mont_precompute
    import paillier_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] r_mod,
    output logic [WIDTH-1:0] r2_mod
);

    localparam int CW = $clog2(2*WIDTH+1);
    localparam logic [CW-1:0] LAST_CNT = CW'(2*WIDTH - UNROLL);
    localparam logic [CW-1:0] STEP_CNT = CW'(UNROLL);

    precomp_state_t   state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] rmod_q, rmod_d;
    logic [WIDTH-1:0] r2mod_q, r2mod_d;

    // Tap points of the doubling chain: stage[0] is the held value, stage[i+1]
    // is the value after the (i+1)-th doubling of this clock.
    logic [WIDTH-1:0] stage [UNROLL+1];

    assign stage[0] = x_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_chain
        mod_double #(.WIDTH(WIDTH)) u_double (
            .x_i (stage[g]),
            .n_i (n_q),
            .y_o (stage[g+1])
        );
    end

    // Next-state and datapath control; a start arriving during the done
    // cycle is dropped so a finishing run cannot be chained unintentionally.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        rmod_d  = rmod_q;
        r2mod_d = r2mod_q;

        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    n_d     = modulus;
                    error_d = 1'b0;
                    rmod_d  = '0;
                    r2mod_d = '0;
                    state_d = INIT;
                end
            end
            INIT: begin
                busy_d = 1'b1;
                if (!n_q[0] || (n_q <= WIDTH'(1))) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    x_d     = WIDTH'(1);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d   = stage[UNROLL];
                cnt_d = cnt_q + STEP_CNT;
                for (int i = 0; i < UNROLL; i++) begin
                    if (cnt_q == CW'(WIDTH - 1 - i)) begin
                        rmod_d = stage[i+1];
                    end
                end
                if (cnt_q == LAST_CNT) begin
                    r2mod_d = stage[UNROLL];
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any run and clears all outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            rmod_q  <= '0;
            r2mod_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            rmod_q  <= rmod_d;
            r2mod_q <= r2mod_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;
    assign r_mod  = rmod_q;
    assign r2_mod = r2mod_q;

endmodule

// File: tb/tb_mont_precompute.sv
// Scoreboard bench for mont_precompute: two 8-bit instances (one and four doublings
// per clock) share the stimulus; each has its own expected-result queue and monitor.
module tb_mont_precompute;

    typedef struct {
        logic [7:0] r;
        logic [7:0] r2;
        logic       err;
        int         doneCyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] modulus = 8'd0;

    logic       busyA, doneA, errorA;
    logic [7:0] rA, r2A;
    logic       busyB, doneB, errorB;
    logic [7:0] rB, r2B;

    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t qA[$];
    exp_t qB[$];
    exp_t eA, eB;

    mont_precompute #(.WIDTH(8), .UNROLL(1)) dutA (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .modulus (modulus),
        .busy    (busyA),
        .done    (doneA),
        .error   (errorA),
        .r_mod   (rA),
        .r2_mod  (r2A)
    );

    mont_precompute #(.WIDTH(8), .UNROLL(4)) dutB (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .modulus (modulus),
        .busy    (busyB),
        .done    (doneB),
        .error   (errorB),
        .r_mod   (rB),
        .r2_mod  (r2B)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc holds k.
    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: count it, and report it when the values differ.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // A comparison that failed outright (unexpected event or expired wait).
    task automatic noteFail(input string name);
        checks++;
        $display("[TB] FAIL %s", name);
    endtask

    // Issue one start and queue the expected results for the selected instances.
    task automatic applyStimulus(input logic [7:0] n, input logic [7:0] er, input logic [7:0] er2,
                                 input logic err, input bit toA, input bit toB);
        int t;
        @(negedge clk);
        start   = 1'b1;
        modulus = n;
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b0;
        if (toA) qA.push_back('{er, er2, err, t + 2 + (err ? 0 : 16)});
        if (toB) qB.push_back('{er, er2, err, t + 2 + (err ? 0 : 4)});
    endtask

    // Wait, with a cycle budget, until both scoreboards have drained.
    task automatic waitIdle();
        for (int i = 0; i < 100; i++) begin
            if (qA.size() == 0 && qB.size() == 0) break;
            @(negedge clk);
        end
        if (qA.size() != 0 || qB.size() != 0) begin
            noteFail("timeout waiting for done");
            qA.delete();
            qB.delete();
        end
    endtask

    // Check that one instance presents all-zero outputs.
    task automatic checkZeroA(input string tag);
        checkOutput({tag, " A busy"}, busyA, 0);
        checkOutput({tag, " A done"}, doneA, 0);
        checkOutput({tag, " A error"}, errorA, 0);
        checkOutput({tag, " A r_mod"}, rA, 0);
        checkOutput({tag, " A r2_mod"}, r2A, 0);
    endtask

    task automatic checkZeroB(input string tag);
        checkOutput({tag, " B busy"}, busyB, 0);
        checkOutput({tag, " B done"}, doneB, 0);
        checkOutput({tag, " B error"}, errorB, 0);
        checkOutput({tag, " B r_mod"}, rB, 0);
        checkOutput({tag, " B r2_mod"}, r2B, 0);
    endtask

    // Monitor for the single-step instance: every done pulse must match the
    // oldest queued expectation, including the cycle it arrives in.
    always @(negedge clk) begin
        if (doneA) begin
            if (qA.size() == 0) begin
                noteFail("A unexpected done");
            end else begin
                eA = qA.pop_front();
                checkOutput("A r_mod", rA, eA.r);
                checkOutput("A r2_mod", r2A, eA.r2);
                checkOutput("A error", errorA, eA.err);
                checkOutput("A done cycle", cyc, eA.doneCyc);
                checkOutput("A busy at done", busyA, 0);
            end
        end
    end

    // Monitor for the four-step instance, same rules.
    always @(negedge clk) begin
        if (doneB) begin
            if (qB.size() == 0) begin
                noteFail("B unexpected done");
            end else begin
                eB = qB.pop_front();
                checkOutput("B r_mod", rB, eB.r);
                checkOutput("B r2_mod", r2B, eB.r2);
                checkOutput("B error", errorB, eB.err);
                checkOutput("B done cycle", cyc, eB.doneCyc);
                checkOutput("B busy at done", busyB, 0);
            end
        end
    end

    // Directed sequence: reset, nominal moduli, error moduli, ignored starts,
    // and a reset in the middle of a run.
    initial begin
        int t;
        bit seen;

        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkZeroA("reset");
        checkZeroB("reset");
        rst = 1'b1;
        @(negedge clk);
        checkZeroA("post-reset");
        checkZeroB("post-reset");

        // Nominal N=13, then check results hold while idle.
        applyStimulus(8'd13, 8'd9, 8'd3, 1'b0, 1'b1, 1'b1);
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("hold A r_mod", rA, 9);
        checkOutput("hold A r2_mod", r2A, 3);
        checkOutput("hold B r_mod", rB, 9);
        checkOutput("hold B r2_mod", r2B, 3);

        // Back-to-back large moduli.
        applyStimulus(8'd251, 8'd5, 8'd25, 1'b0, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(8'd255, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1);
        waitIdle();

        // Illegal moduli: even, one, zero.
        applyStimulus(8'd12, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(8'd1, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(8'd254, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1);
        waitIdle();

        // More legal moduli, including ones without the MSB set.
        applyStimulus(8'd7, 8'd4, 8'd2, 1'b0, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(8'd129, 8'd127, 8'd4, 1'b0, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(8'd11, 8'd3, 8'd9, 1'b0, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(8'd3, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1);
        waitIdle();

        // A second start with a new modulus while both instances are busy.
        applyStimulus(8'd13, 8'd9, 8'd3, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        modulus = 8'd251;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();
        repeat (20) @(negedge clk);

        // A start during A's done cycle: A ignores it, idle B takes it.
        applyStimulus(8'd13, 8'd9, 8'd3, 1'b0, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (doneA) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) noteFail("timeout waiting for A done");
        start   = 1'b1;
        modulus = 8'd7;
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b0;
        qB.push_back('{8'd4, 8'd2, 1'b0, t + 6});
        waitIdle();
        repeat (20) @(negedge clk);
        checkOutput("done-cycle start A r_mod", rA, 9);
        checkOutput("done-cycle start A r2_mod", r2A, 3);
        checkOutput("done-cycle start B r_mod", rB, 4);

        // Reset in the middle of a run: immediate clear, no done afterwards.
        @(negedge clk);
        start   = 1'b1;
        modulus = 8'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid-run A busy", busyA, 1);
        rst = 1'b0;
        #1;
        checkZeroA("mid-run reset");
        checkZeroB("mid-run reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        checkZeroA("after abort");
        applyStimulus(8'd13, 8'd9, 8'd3, 1'b0, 1'b1, 1'b1);
        waitIdle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
